// File: rtl/riscv_pkg.sv
// Shared RV64 decode definitions: base opcodes, immediate formats, default XLEN.
// Pure declarations and helpers, no state.
package riscv_pkg;

  localparam int XLEN_DEF = 64;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;

  typedef enum logic [2:0] {
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_R
  } imm_fmt_e;

  // Unsupported opcodes fall into FMT_R so they produce a zero immediate.
  function automatic imm_fmt_e op_fmt(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_IMM, OP_IMM32, OP_JALR: op_fmt = FMT_I;
      OP_STORE:                           op_fmt = FMT_S;
      OP_BRANCH:                          op_fmt = FMT_B;
      OP_LUI, OP_AUIPC:                   op_fmt = FMT_U;
      OP_JAL:                             op_fmt = FMT_J;
      default:                            op_fmt = FMT_R;
    endcase
  endfunction

  function automatic logic op_legal(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_STORE, OP_BRANCH,
      OP_LUI, OP_AUIPC, OP_JAL, OP_REG, OP_REG32: op_legal = 1'b1;
      default:                                    op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instruction_decode_if.sv
// Fetch/write-back inputs and ID/EX outputs of the decode stage.
// master drives fetch/control/write-back side; slave is the decode stage.
interface instruction_decode_if
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
);
  logic            in_valid;
  logic [31:0]     instruction;
  logic [XLEN-1:0] pc;
  logic            stall;
  logic            flush;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] imm;
  logic [4:0]      rd;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            illegal;

  modport master (
    output in_valid, instruction, pc, stall, flush, wb_en, wb_rd, wb_data,
    input  out_valid, out_pc, rs1_data, rs2_data, imm, rd, opcode, funct3, funct7, illegal
  );

  modport slave (
    input  in_valid, instruction, pc, stall, flush, wb_en, wb_rd, wb_data,
    output out_valid, out_pc, rs1_data, rs2_data, imm, rd, opcode, funct3, funct7, illegal
  );

endinterface

// File: rtl/register_file.sv
// 2R/1W register file, x0 hardwired to zero, same-cycle write-back bypass on reads.
// Reads combinational; write lands at the clock edge; no backpressure.
module register_file
  import riscv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_dat,
  input  logic [AW-1:0]   rd_addr_a,
  output logic [XLEN-1:0] rd_dat_a,
  input  logic [AW-1:0]   rd_addr_b,
  output logic [XLEN-1:0] rd_dat_b
);

  logic [NREGS-1:0][XLEN-1:0] mem_q;
  logic [NREGS-1:0][XLEN-1:0] mem_d;
  logic                       wr_hit;

  assign wr_hit = wr_en && (wr_addr != '0);

  always_comb begin
    mem_d = mem_q;
    if (wr_hit) begin
      mem_d[wr_addr] = wr_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Bypass makes a write visible to a read in the same cycle.
  always_comb begin
    rd_dat_a = '0;
    if (rd_addr_a != '0) begin
      rd_dat_a = (wr_hit && (wr_addr == rd_addr_a)) ? wr_dat : mem_q[rd_addr_a];
    end
  end

  always_comb begin
    rd_dat_b = '0;
    if (rd_addr_b != '0) begin
      rd_dat_b = (wr_hit && (wr_addr == rd_addr_b)) ? wr_dat : mem_q[rd_addr_b];
    end
  end

endmodule

// File: rtl/instruction_decode.sv
// RV64 decode stage: operand read, immediate generation, ID/EX register bank.
// 1-cycle latency; stall holds the bank, flush inserts a bubble (flush wins).
module instruction_decode
  import riscv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  instruction_decode_if.slave  bus
);

  logic [31:0]     inst;
  logic [6:0]      op;
  imm_fmt_e        fmt;
  logic [XLEN-1:0] imm_dec;
  logic [XLEN-1:0] rs1_rf;
  logic [XLEN-1:0] rs2_rf;

  assign inst = bus.instruction;
  assign op   = inst[6:0];
  assign fmt  = op_fmt(op);

  register_file #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_rf (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (bus.wb_en),
    .wr_addr   (bus.wb_rd),
    .wr_dat    (bus.wb_data),
    .rd_addr_a (inst[19:15]),
    .rd_dat_a  (rs1_rf),
    .rd_addr_b (inst[24:20]),
    .rd_dat_b  (rs2_rf)
  );

  always_comb begin
    imm_dec = '0;
    case (fmt)
      FMT_I: imm_dec = {{(XLEN-12){inst[31]}}, inst[31:20]};
      FMT_S: imm_dec = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B: imm_dec = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U: imm_dec = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
      FMT_J: imm_dec = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm_dec = '0;
    endcase
  end

  logic            valid_q,   valid_d;
  logic [XLEN-1:0] pc_q,      pc_d;
  logic [XLEN-1:0] rs1_q,     rs1_d;
  logic [XLEN-1:0] rs2_q,     rs2_d;
  logic [XLEN-1:0] imm_q,     imm_d;
  logic [4:0]      rd_q,      rd_d;
  logic [6:0]      opcode_q,  opcode_d;
  logic [2:0]      funct3_q,  funct3_d;
  logic [6:0]      funct7_q,  funct7_d;
  logic            illegal_q, illegal_d;

  // Fields load even when in_valid=0; only the valid/illegal flags are qualified.
  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    imm_d     = imm_q;
    rd_d      = rd_q;
    opcode_d  = opcode_q;
    funct3_d  = funct3_q;
    funct7_d  = funct7_q;
    illegal_d = illegal_q;
    if (bus.flush) begin
      valid_d   = 1'b0;
      illegal_d = 1'b0;
    end else if (!bus.stall) begin
      valid_d   = bus.in_valid;
      pc_d      = bus.pc;
      rs1_d     = rs1_rf;
      rs2_d     = rs2_rf;
      imm_d     = imm_dec;
      rd_d      = inst[11:7];
      opcode_d  = op;
      funct3_d  = inst[14:12];
      funct7_d  = inst[31:25];
      illegal_d = bus.in_valid && !op_legal(op);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      imm_q     <= '0;
      rd_q      <= '0;
      opcode_q  <= '0;
      funct3_q  <= '0;
      funct7_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      imm_q     <= imm_d;
      rd_q      <= rd_d;
      opcode_q  <= opcode_d;
      funct3_q  <= funct3_d;
      funct7_q  <= funct7_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_pc    = pc_q;
  assign bus.rs1_data  = rs1_q;
  assign bus.rs2_data  = rs2_q;
  assign bus.imm       = imm_q;
  assign bus.rd        = rd_q;
  assign bus.opcode    = opcode_q;
  assign bus.funct3    = funct3_q;
  assign bus.funct7    = funct7_q;
  assign bus.illegal   = illegal_q;

endmodule
